// File: rtl/multi_lane_hash_validator.sv
// multi_lane_hash_validator: checks LANES hashes per beat against a leading-zero
// difficulty, tracks the nonce of every lane through a 2-stage pipeline and
// captures the lowest winning nonce into a SEARCH/HOLD result register.
// Optional feature macro: HASH_VALIDATOR_STATS_EN adds saturating beat/hit counters.

// Per-lane difficulty check: hit when the top min(diff, HASH_W) bits are zero.
module mlhv_lane_cmp #(
    parameter int unsigned HASH_W = 256
) (
    input  logic [HASH_W-1:0] hash,
    input  logic [8:0]        diff,
    output logic              hit
);
    // Bit i sits HASH_W-1-i positions below the MSB; it matters only inside the window.
    always_comb begin
        hit = 1'b1;
        for (int unsigned i = 0; i < HASH_W; i++) begin
            if (((HASH_W - 1 - i) < 32'(diff)) && hash[i]) hit = 1'b0;
        end
    end
endmodule

module multi_lane_hash_validator #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned HASH_W  = 256,
    parameter int unsigned NONCE_W = 32,
    parameter int unsigned INDEX   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic                      newblock_i,
    input  logic [LANES*HASH_W-1:0]   hash_i,
    input  logic [8:0]                difficulty_i,
    output logic                      valid_o,
    output logic                      newblock_o,
    output logic                      success_o,
    output logic [LANES-1:0]          lane_hit_o,
    output logic                      res_valid_o,
    output logic [NONCE_W-1:0]        res_nonce_o,
    input  logic                      res_ready_i,
`ifdef HASH_VALIDATOR_STATS_EN
    output logic [31:0]               stat_beats_o,
    output logic [31:0]               stat_hits_o,
`endif
    output logic                      res_overflow_o
);
    localparam int unsigned STAGES = 2;

    typedef enum logic {SEARCH, HOLD} state_t;

    logic [LANES-1:0]                 lane_hit_c;
    logic [STAGES:0]                  vld_pipe;
    logic [STAGES:1]                  vld_pipe_q, vld_pipe_d;
    logic [STAGES:1]                  nb_pipe_q, nb_pipe_d;
    logic [STAGES:1][LANES-1:0]       hit_pipe_q, hit_pipe_d;
    logic [STAGES:1][NONCE_W-1:0]     base_pipe_q, base_pipe_d;
    logic [NONCE_W-1:0]               base_q, base_d, beat_base;
    logic [NONCE_W-1:0]               win_nonce;
    state_t                           state_q, state_d;
    logic [NONCE_W-1:0]               res_nonce_q, res_nonce_d;
    logic                             ovf_q, ovf_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mlhv_lane_cmp #(.HASH_W(HASH_W)) u_cmp (
            .hash (hash_i[k*HASH_W +: HASH_W]),
            .diff (difficulty_i),
            .hit  (lane_hit_c[k])
        );
    end

    assign vld_pipe = {vld_pipe_q, valid_i};

    // Base nonce per beat plus the pipeline shift; hits are gated by valid at entry
    // so every later stage is already zero on idle beats.
    always_comb begin
        beat_base   = newblock_i ? NONCE_W'(INDEX) : base_q + NONCE_W'(LANES);
        base_d      = valid_i ? beat_base : base_q;
        vld_pipe_d  = vld_pipe_q;
        nb_pipe_d   = nb_pipe_q;
        hit_pipe_d  = hit_pipe_q;
        base_pipe_d = base_pipe_q;
        vld_pipe_d[1]  = vld_pipe[0];
        nb_pipe_d[1]   = valid_i & newblock_i;
        hit_pipe_d[1]  = valid_i ? lane_hit_c : '0;
        base_pipe_d[1] = beat_base;
        for (int unsigned s = 2; s <= STAGES; s++) begin
            vld_pipe_d[s]  = vld_pipe[s-1];
            nb_pipe_d[s]   = nb_pipe_q[s-1];
            hit_pipe_d[s]  = hit_pipe_q[s-1];
            base_pipe_d[s] = base_pipe_q[s-1];
        end
    end

    // Pipeline and base register; reset discards in-flight beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q      <= NONCE_W'(INDEX);
            vld_pipe_q  <= '0;
            nb_pipe_q   <= '0;
            hit_pipe_q  <= '0;
            base_pipe_q <= '0;
        end else begin
            base_q      <= base_d;
            vld_pipe_q  <= vld_pipe_d;
            nb_pipe_q   <= nb_pipe_d;
            hit_pipe_q  <= hit_pipe_d;
            base_pipe_q <= base_pipe_d;
        end
    end

    assign valid_o    = vld_pipe_q[STAGES];
    assign newblock_o = nb_pipe_q[STAGES];
    assign lane_hit_o = hit_pipe_q[STAGES];
    assign success_o  = |hit_pipe_q[STAGES];

    // Lowest-indexed hit lane wins: scan downward so the lowest lane assigns last.
    always_comb begin
        win_nonce = base_pipe_q[STAGES];
        for (int k = int'(LANES) - 1; k >= 0; k--) begin
            if (hit_pipe_q[STAGES][k]) win_nonce = base_pipe_q[STAGES] + NONCE_W'(k);
        end
    end

    // Result FSM: capture in SEARCH, hold until handshake; a win during an idle
    // hold is dropped and flagged. Overflow set takes priority over a newblock clear.
    always_comb begin
        state_d     = state_q;
        res_nonce_d = res_nonce_q;
        ovf_d       = ovf_q;
        if (newblock_o) ovf_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (success_o) begin
                    res_nonce_d = win_nonce;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (res_ready_i) begin
                    if (success_o) res_nonce_d = win_nonce;
                    else           state_d     = SEARCH;
                end else if (success_o) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Result state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEARCH;
            res_nonce_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_nonce_q <= res_nonce_d;
            ovf_q       <= ovf_d;
        end
    end

    assign res_valid_o    = (state_q == HOLD);
    assign res_nonce_o    = res_nonce_q;
    assign res_overflow_o = ovf_q;

`ifdef HASH_VALIDATOR_STATS_EN
    logic [31:0] beats_q, beats_d, hits_q, hits_d;

    // Saturating counters; a newblock beat restarts both and counts as the first beat.
    always_comb begin
        beats_d = beats_q;
        hits_d  = hits_q;
        if (newblock_o) begin
            beats_d = 32'd1;
            hits_d  = success_o ? 32'd1 : 32'd0;
        end else if (valid_o) begin
            if (beats_q != '1)            beats_d = beats_q + 32'd1;
            if (success_o && hits_q != '1) hits_d = hits_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats_q <= '0;
            hits_q  <= '0;
        end else begin
            beats_q <= beats_d;
            hits_q  <= hits_d;
        end
    end

    assign stat_beats_o = beats_q;
    assign stat_hits_o  = hits_q;
`endif
endmodule

// File: tb/tb_multi_lane_hash_validator.sv
// Bench for multi_lane_hash_validator: two instances share stimulus, one with
// INDEX=8 and one with INDEX=0xFFFFFFFA so nonce wrap is reachable in a few beats.
// Per-beat outputs are checked from a scoreboard queue; result-register
// behaviour is checked at directed points.
module tb_multi_lane_hash_validator;
    localparam int LANES = 4;
    localparam int HW    = 256;
    localparam int NW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid_i = 1'b0, newblock_i = 1'b0, res_ready_i = 1'b0;
    logic [8:0] diff = '0;
    logic [HW-1:0] lh [LANES];
    logic [LANES*HW-1:0] hash_i;

    logic a_valid, a_nb, a_succ, a_rv, a_ovf;
    logic [LANES-1:0] a_hit;
    logic [NW-1:0] a_rn;
    logic b_valid, b_nb, b_succ, b_rv, b_ovf;
    logic [LANES-1:0] b_hit;
    logic [NW-1:0] b_rn;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic v;
        logic nb;
        logic [LANES-1:0] hits;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    always_comb begin
        hash_i = '0;
        for (int k = 0; k < LANES; k++) hash_i[k*HW +: HW] = lh[k];
    end

    multi_lane_hash_validator #(.LANES(LANES), .HASH_W(HW), .NONCE_W(NW), .INDEX(8)) u_a (
        .clk(clk), .rst(rst), .valid_i(valid_i), .newblock_i(newblock_i), .hash_i(hash_i),
        .difficulty_i(diff), .valid_o(a_valid), .newblock_o(a_nb), .success_o(a_succ),
        .lane_hit_o(a_hit), .res_valid_o(a_rv), .res_nonce_o(a_rn), .res_ready_i(res_ready_i),
        .res_overflow_o(a_ovf));

    multi_lane_hash_validator #(.LANES(LANES), .HASH_W(HW), .NONCE_W(NW), .INDEX(32'hFFFF_FFFA)) u_b (
        .clk(clk), .rst(rst), .valid_i(valid_i), .newblock_i(newblock_i), .hash_i(hash_i),
        .difficulty_i(diff), .valid_o(b_valid), .newblock_o(b_nb), .success_o(b_succ),
        .lane_hit_o(b_hit), .res_valid_o(b_rv), .res_nonce_o(b_rn), .res_ready_i(res_ready_i),
        .res_overflow_o(b_ovf));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: count leading zeros, compare with the clamped difficulty.
    function automatic logic [LANES-1:0] ref_hits(input logic [8:0] d);
        logic [LANES-1:0] r;
        int lim;
        lim = (int'(d) > HW) ? HW : int'(d);
        for (int k = 0; k < LANES; k++) begin
            int z;
            bit done;
            z = 0;
            done = 1'b0;
            for (int b = HW - 1; b >= 0; b--) begin
                if (!done) begin
                    if (lh[k][b] == 1'b0) z++;
                    else done = 1'b1;
                end
            end
            r[k] = (z >= lim);
        end
        return r;
    endfunction

    task automatic lanes_miss();
        for (int k = 0; k < LANES; k++) lh[k] = {HW{1'b1}};
    endtask

    // One clock of stimulus; the beat driven two steps earlier is checked here.
    task automatic step(input logic v, input logic nb, input logic [8:0] d);
        exp_t e;
        valid_i    = v;
        newblock_i = nb;
        diff       = d;
        e.v    = v;
        e.nb   = v & nb;
        e.hits = v ? ref_hits(d) : '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            chk("a_valid_o",    a_valid, e.v);
            chk("a_newblock_o", a_nb,    e.nb);
            chk("a_lane_hit_o", a_hit,   e.hits);
            chk("a_success_o",  a_succ,  |e.hits);
            chk("b_valid_o",    b_valid, e.v);
            chk("b_lane_hit_o", b_hit,   e.hits);
        end
    endtask

    initial begin
        logic [8:0] dtab [7];
        dtab = '{9'd0, 9'd16, 9'd17, 9'd255, 9'd256, 9'd300, 9'd511};
        lanes_miss();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o",   a_valid, 1'b0);
        chk("rst_newblock",  a_nb,    1'b0);
        chk("rst_success",   a_succ,  1'b0);
        chk("rst_lane_hit",  a_hit,   4'h0);
        chk("rst_res_valid", a_rv,    1'b0);
        chk("rst_res_nonce", a_rn,    32'h0);
        chk("rst_overflow",  a_ovf,   1'b0);
        rst = 1'b1;

        // newblock beat, lane 2 top 16 bits zero, difficulty 16
        lh[2] = {HW{1'b1}} >> 16;
        step(1'b1, 1'b1, 9'd16);
        step(1'b0, 1'b0, 9'd16);
        chk("a_res_valid_before_load", a_rv, 1'b0);
        step(1'b0, 1'b0, 9'd16);
        chk("a_res_valid_first", a_rv, 1'b1);
        chk("a_res_nonce_first", a_rn, 32'd10);
        chk("b_res_nonce_first", b_rn, 32'hFFFF_FFFC);
        res_ready_i = 1'b1;
        step(1'b0, 1'b0, 9'd16);
        chk("a_res_valid_after_ack", a_rv, 1'b0);
        res_ready_i = 1'b0;

        // third beat after newblock, lanes 1 and 3 hit
        lanes_miss();
        step(1'b1, 1'b1, 9'd16);
        step(1'b1, 1'b0, 9'd16);
        lh[1] = {HW{1'b1}} >> 16;
        lh[3] = {HW{1'b1}} >> 16;
        step(1'b1, 1'b0, 9'd16);
        lanes_miss();
        step(1'b0, 1'b0, 9'd16);
        step(1'b0, 1'b0, 9'd16);
        chk("a_res_valid_lowlane", a_rv, 1'b1);
        chk("a_res_nonce_lowlane", a_rn, 32'd17);
        chk("b_res_nonce_lowlane", b_rn, 32'd3);

        // hit while held without ready: dropped, overflow sticky
        step(1'b1, 1'b0, 9'd0);
        step(1'b0, 1'b0, 9'd16);
        step(1'b0, 1'b0, 9'd16);
        chk("a_res_nonce_kept", a_rn, 32'd17);
        chk("a_overflow_set",   a_ovf, 1'b1);
        chk("a_res_valid_held", a_rv, 1'b1);
        // newblock clears overflow but not the held result
        step(1'b1, 1'b1, 9'd16);
        step(1'b0, 1'b0, 9'd16);
        step(1'b0, 1'b0, 9'd16);
        chk("a_overflow_cleared", a_ovf, 1'b0);
        chk("a_res_valid_survive", a_rv, 1'b1);
        chk("a_res_nonce_survive", a_rn, 32'd17);
        res_ready_i = 1'b1;
        step(1'b0, 1'b0, 9'd16);
        res_ready_i = 1'b0;
        chk("a_res_valid_released", a_rv, 1'b0);

        // wrap: b bases are FFFFFFFA, FFFFFFFE, 2; lane 1 hit on the wrap beat,
        // then lane 3 hit accepted together with the handshake
        lanes_miss();
        step(1'b1, 1'b1, 9'd16);
        lh[1] = {HW{1'b1}} >> 16;
        step(1'b1, 1'b0, 9'd16);
        lanes_miss();
        lh[3] = {HW{1'b1}} >> 16;
        step(1'b1, 1'b0, 9'd16);
        lanes_miss();
        step(1'b0, 1'b0, 9'd16);
        chk("b_res_valid_wrap", b_rv, 1'b1);
        chk("b_res_nonce_wrap", b_rn, 32'hFFFF_FFFF);
        chk("a_res_nonce_wrap", a_rn, 32'd13);
        res_ready_i = 1'b1;
        step(1'b0, 1'b0, 9'd16);
        res_ready_i = 1'b0;
        chk("b_res_valid_concurrent", b_rv, 1'b1);
        chk("b_res_nonce_concurrent", b_rn, 32'd5);
        chk("a_res_nonce_concurrent", a_rn, 32'd19);
        chk("a_overflow_concurrent",  a_ovf, 1'b0);
        res_ready_i = 1'b1;
        step(1'b0, 1'b0, 9'd16);
        res_ready_i = 1'b0;

        // difficulty boundaries: lane0 all zero, lane1 = 1, lane2 16 zeros, lane3 all ones
        lh[0] = '0;
        lh[1] = HW'(1);
        lh[2] = {HW{1'b1}} >> 16;
        lh[3] = {HW{1'b1}};
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, dtab[i]);
        step(1'b1, 1'b0, 9'd0);
        step(1'b1, 1'b0, 9'd0);

        // asynchronous reset with a held result and beats in flight
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid_o",   a_valid, 1'b0);
        chk("arst_newblock",  a_nb,    1'b0);
        chk("arst_success",   a_succ,  1'b0);
        chk("arst_lane_hit",  a_hit,   4'h0);
        chk("arst_res_valid", a_rv,    1'b0);
        chk("arst_res_nonce", a_rn,    32'h0);
        chk("arst_overflow",  a_ovf,   1'b0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 9'd0);
        chk("post_rst_valid_1", a_valid, 1'b0);
        step(1'b0, 1'b0, 9'd0);
        chk("post_rst_valid_2", a_valid, 1'b0);
        chk("post_rst_res_valid", a_rv, 1'b0);

        // base restarts at INDEX: first non-newblock beat uses INDEX+LANES
        step(1'b1, 1'b0, 9'd0);
        step(1'b0, 1'b0, 9'd0);
        step(1'b0, 1'b0, 9'd0);
        chk("a_res_nonce_after_rst", a_rn, 32'd12);
        chk("b_res_nonce_after_rst", b_rn, 32'hFFFF_FFFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
